// File: rtl/fact_sched.sv
// Round-robin job scheduler sharing the factorial accelerator's register port
// between two requesters: write n, start, poll status, read result, clear start.
module fact_sched #(
    parameter int unsigned POLL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [3:0]  n0,
    input  logic        req1,
    input  logic [3:0]  n1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic [1:0]  fact_a,
    output logic        fact_we,
    output logic [3:0]  fact_wd,
    input  logic [31:0] fact_rd
);

    localparam logic [7:0] LP_CNT_LAST = 8'(POLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        POLL,
        READ,
        ACK
    } state_t;

    state_t      r_state;
    logic        r_gid;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_result;
    logic        r_err;
    logic        r_busy;
    logic [1:0]  r_a;
    logic        r_we;
    logic [3:0]  r_wd;

    logic        w_grant1;
    logic [3:0]  w_n_sel;
    logic        w_poll_fail;

    // On a tie the requester that was not granted last time wins.
    assign w_grant1    = req1 & (~req0 | ~r_last);
    assign w_n_sel     = w_grant1 ? n1 : n0;
    assign w_poll_fail = fact_rd[1] | (~fact_rd[0] & (r_cnt == LP_CNT_LAST));

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign result  = r_result;
    assign err     = r_err;
    assign busy    = r_busy;
    assign fact_a  = r_a;
    assign fact_we = r_we;
    assign fact_wd = r_wd;

    // Port outputs are registered, so each branch loads the values for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gid    <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= 8'd0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_result <= 32'd0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_a      <= 2'd0;
            r_we     <= 1'b0;
            r_wd     <= 4'd0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state <= WR_N;
                        r_gid   <= w_grant1;
                        r_last  <= w_grant1;
                        r_busy  <= 1'b1;
                        r_a     <= 2'd0;
                        r_we    <= 1'b1;
                        r_wd    <= w_n_sel;
                    end
                end
                WR_N: begin
                    r_state <= WR_GO;
                    r_a     <= 2'd1;
                    r_we    <= 1'b1;
                    r_wd    <= 4'd1;
                end
                WR_GO: begin
                    r_state <= POLL;
                    r_cnt   <= 8'd0;
                    r_a     <= 2'd2;
                    r_we    <= 1'b0;
                    r_wd    <= 4'd0;
                end
                POLL: begin
                    if (w_poll_fail) begin
                        r_state  <= ACK;
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                        r_ack0   <= ~r_gid;
                        r_ack1   <= r_gid;
                        r_a      <= 2'd1;
                        r_we     <= 1'b1;
                        r_wd     <= 4'd0;
                    end else if (fact_rd[0]) begin
                        r_state <= READ;
                        r_a     <= 2'd3;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                READ: begin
                    r_state  <= ACK;
                    r_result <= fact_rd;
                    r_err    <= 1'b0;
                    r_ack0   <= ~r_gid;
                    r_ack1   <= r_gid;
                    r_a      <= 2'd1;
                    r_we     <= 1'b1;
                    r_wd     <= 4'd0;
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_a     <= 2'd0;
                    r_we    <= 1'b0;
                    r_wd    <= 4'd0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fact_sched.sv
// Directed bench for fact_sched with a behavioural factorial accelerator whose
// status (done / err) rises on a chosen POLL cycle of each job.
module tb_fact_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [3:0]  n0 = 4'd0;
    logic [3:0]  n1 = 4'd0;
    logic        ack0, ack1, err, busy, fact_we;
    logic [31:0] result;
    logic [1:0]  fact_a;
    logic [3:0]  fact_wd;
    logic [31:0] fact_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Accelerator model controls: 1-based POLL cycle where done / err rise (0 = never)
    int         done_at = 0;
    int         err_at  = 0;
    int         poll_idx = 0;
    logic [3:0] m_n = 4'd0;

    fact_sched #(.POLL_TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .n0      (n0),
        .req1    (req1),
        .n1      (n1),
        .ack0    (ack0),
        .ack1    (ack1),
        .result  (result),
        .err     (err),
        .busy    (busy),
        .fact_a  (fact_a),
        .fact_we (fact_we),
        .fact_wd (fact_wd),
        .fact_rd (fact_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact_fn(input logic [3:0] n);
        logic [31:0] f;
        f = 32'd1;
        for (int k = 2; k <= int'(n); k++) f = f * 32'(k);
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            poll_idx <= 0;
            m_n      <= 4'd0;
        end else if (fact_we && fact_a == 2'd0) begin
            m_n <= fact_wd;
        end else if (fact_we && fact_a == 2'd1 && fact_wd == 4'd1) begin
            poll_idx <= 0;
        end else if (fact_a == 2'd2) begin
            poll_idx <= poll_idx + 1;
        end
    end

    always_comb begin
        fact_rd = 32'd0;
        case (fact_a)
            2'd0: fact_rd = {28'd0, m_n};
            2'd2: begin
                fact_rd[1] = (err_at != 0) && (poll_idx + 1 >= err_at);
                fact_rd[0] = (done_at != 0) && (poll_idx + 1 >= done_at);
            end
            2'd3: fact_rd = fact_fn(m_n);
            default: fact_rd = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until an ack; cyc counts clock edges from the call (-1 if none within budget).
    // The acked requester drops req in the ack cycle.
    task automatic wait_ack(output int cyc, output logic who, output logic [31:0] res,
                            output logic e, output logic saw_rd, output logic clr,
                            output int polls);
        cyc    = -1;
        who    = 1'b0;
        res    = 32'd0;
        e      = 1'b0;
        saw_rd = 1'b0;
        clr    = 1'b0;
        polls  = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (fact_a == 2'd3) saw_rd = 1'b1;
            if (fact_a == 2'd2 && !fact_we) polls++;
            if (ack0 || ack1) begin
                cyc = i;
                who = ack1;
                res = result;
                e   = err;
                clr = (fact_a == 2'd1) && fact_we && (fact_wd == 4'd0);
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack0"},   32'(ack0),    32'd0);
        check({tag, "_ack1"},   32'(ack1),    32'd0);
        check({tag, "_busy"},   32'(busy),    32'd0);
        check({tag, "_result"}, result,       32'd0);
        check({tag, "_err"},    32'(err),     32'd0);
        check({tag, "_fact_a"}, 32'(fact_a),  32'd0);
        check({tag, "_we"},     32'(fact_we), 32'd0);
        check({tag, "_wd"},     32'(fact_wd), 32'd0);
    endtask

    initial begin
        int          cyc, polls;
        logic        who, e, saw_rd, clr;
        logic [31:0] res;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single job: n=5, done on 3rd POLL
        done_at = 3;
        req0 = 1'b1; n0 = 4'd5;
        tick();
        check("single_wrn_a",  32'(fact_a),  32'd0);
        check("single_wrn_we", 32'(fact_we), 32'd1);
        check("single_wrn_wd", 32'(fact_wd), 32'd5);
        check("single_busy",   32'(busy),    32'd1);
        tick();
        check("single_go_a",  32'(fact_a),  32'd1);
        check("single_go_we", 32'(fact_we), 32'd1);
        check("single_go_wd", 32'(fact_wd), 32'd1);
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("single_ack_cycle", 32'(cyc + 2), 32'd7);
        check("single_who",    32'(who), 32'd0);
        check("single_result", res,      32'd120);
        check("single_err",    32'(e),   32'd0);
        check("single_clr",    32'(clr), 32'd1);
        check("single_polls",  32'(polls), 32'd3);
        check("single_ack_busy", 32'(busy), 32'd1);
        tick();
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_hold_res",  result,    32'd120);

        // Tie after reset: requester 0 first, then 1 after one idle cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; n0 = 4'd3;
        req1 = 1'b1; n1 = 4'd4;
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("tie_first_cycle",  32'(cyc), 32'd7);
        check("tie_first_who",    32'(who), 32'd0);
        check("tie_first_result", res,      32'd6);
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("tie_second_cycle",  32'(cyc), 32'd8);
        check("tie_second_who",    32'(who), 32'd1);
        check("tie_second_result", res,      32'd24);
        tick();

        // Round-robin: both held, acked requester re-raises in the following idle cycle
        done_at = 1;
        req0 = 1'b1; n0 = 4'd2;
        req1 = 1'b1; n1 = 4'd3;
        for (int j = 0; j < 4; j++) begin
            wait_ack(cyc, who, res, e, saw_rd, clr, polls);
            check($sformatf("rr%0d_who", j),    32'(who), 32'(j % 2));
            check($sformatf("rr%0d_result", j), res, (j % 2 == 1) ? 32'd6 : 32'd2);
            if (j == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            if (j < 3) begin
                if (who) req1 = 1'b1;
                else     req0 = 1'b1;
            end
        end

        // Accelerator error on the 1st POLL: ack straight from POLL, no READ
        done_at = 0;
        err_at  = 1;
        req1 = 1'b1; n1 = 4'd6;
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("err_cycle",  32'(cyc),    32'd4);
        check("err_who",    32'(who),    32'd1);
        check("err_flag",   32'(e),      32'd1);
        check("err_result", res,         32'd0);
        check("err_noread", 32'(saw_rd), 32'd0);
        tick();
        err_at = 0;

        // Timeout with POLL_TIMEOUT=8
        req0 = 1'b1; n0 = 4'd9;
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("to_cycle",  32'(cyc),   32'd11);
        check("to_polls",  32'(polls), 32'd8);
        check("to_who",    32'(who),   32'd0);
        check("to_flag",   32'(e),     32'd1);
        check("to_result", res,        32'd0);
        check("to_clr",    32'(clr),   32'd1);
        tick();

        // Reset during the 2nd POLL cycle, request still held
        req1 = 1'b1; n1 = 4'd7;
        tick();
        tick();
        tick();
        tick();
        check("rstmid_in_poll", 32'(fact_a), 32'd2);
        rst = 1'b1;
        tick();
        check_idle_outputs("rstmid");
        rst = 1'b0;
        done_at = 2;
        wait_ack(cyc, who, res, e, saw_rd, clr, polls);
        check("rstmid_new_cycle",  32'(cyc), 32'd6);
        check("rstmid_new_who",    32'(who), 32'd1);
        check("rstmid_new_result", res,      32'd5040);
        check("rstmid_new_err",    32'(e),   32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
